multiport_regfile_sb: RTL and testbench
=======================================

Name: multiport_regfile_sb

Overview:
- Parametrised successor to the two-write, four-read register file used by the dual-issue core.
- Generalises data width, register count, write-port count and read-port count.
- Adds a busy-bit scoreboard: decode marks destination registers pending at issue, and writeback clears them. Decode can then stall on RAW hazards without a separate hazard unit.
- Sits between decode/issue and writeback in the superscalar pipeline.

Parameters:
- XLEN, 32, data width per register.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- NWR, 2, number of writeback ports.
- NRD, 4, number of read ports.
- NISS, 2, number of issue ports that set busy bits.
- AW, $clog2(NREGS), address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses; port k occupies bits [k*AW +: AW].
- wr_data  in  NWR*XLEN  packed write data.
- rd_addr  in  NRD*AW  packed read addresses.
- rd_data  out  NRD*XLEN  packed read data (combinational).
- rd_busy  out  NRD  busy bit of each read address (combinational).
- iss_en  in  NISS  per-port issue strobe.
- iss_addr  in  NISS*AW  destination register being issued.
- busy_cnt  out  $clog2(NREGS)+1  registered count of currently busy registers.

Behaviour:
- Reset:
  - Asserting rst_n low asynchronously clears all registers to 0, all busy bits to 0, and busy_cnt to 0.
  - Deassertion is synchronised externally.
  - Reset mid-write or mid-issue discards the operation.
- Register 0:
  - Reads always return 0 with rd_busy=0.
  - Writes to register 0 are ignored.
  - Issue to register 0 never sets busy.
- Writes, one cycle:
  - At posedge, each port k with wr_en[k]=1 and a nonzero address writes its data.
  - Conflict rule: on equal addresses, the lowest-numbered enabled port wins; higher ports are dropped for that address.
- Reads:
  - Purely combinational from array state.
  - Without the optional feature, a same-cycle write is not visible until the next cycle.
- Scoreboard, per register r, evaluated at posedge:
  - set = any iss_en[j] with iss_addr[j]==r.
  - clr = any wr_en[k] with wr_addr[k]==r.
  - busy[r] next = set ? 1 : (clr ? 0 : busy[r]).
  - Set beats clear: a new producer issued in the same cycle as the old producer's writeback leaves the register busy.
  - Duplicate issue to the same register in one cycle sets busy once.
  - Writeback to a non-busy register writes data and leaves busy at 0 (no error).
- busy_cnt:
  - Registered popcount of the next-state busy vector, so it matches the busy bits in the same cycle they change.
  - Range 0..NREGS-1, since register 0 is never busy.
- Latency:
  - Write to read-visible: 1 cycle.
  - Issue to rd_busy=1: 1 cycle.
  - Writeback to rd_busy=0: 1 cycle.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined:
  - rd_data forwards wr_data from any same-cycle enabled write to a matching nonzero address, using the lowest-numbered matching port.
  - rd_busy reads 0 when a same-cycle write clears that register and no same-cycle issue sets it.
  - Write-to-read and clear-to-busy latency both become 0 cycles.
- Undefined: behaviour as above with 1-cycle visibility.
- Both builds must pass the same test plan, with expected latencies adjusted.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN, NREGS, NWR, NRD, NISS constants;
  - the AW derivation function;
  - a popcount function.
- One natural sub-module, rf_scoreboard: owns the busy vector and busy_cnt, with ports clk, rst_n, iss_en/iss_addr, wr_en/wr_addr, rd_addr -> rd_busy.
- The top module owns the data array, write arbitration and read muxing.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with wr_en=2'b11 active -> all rd_data=0, rd_busy=0, busy_cnt=0 immediately, without a clock edge.
- Write conflict: port0 writes x5=0xAAAA_0001 and port1 writes x5=0xBBBB_0002 in the same cycle -> next cycle rd_data for x5 reads 0xAAAA_0001.
- Register 0: write x0=0xFFFF_FFFF with iss_addr=0 -> rd_data=0, rd_busy=0, busy_cnt unchanged.
- Scoreboard lifecycle: issue x7 and x9 -> next cycle rd_busy=1 on both, busy_cnt=2; writeback x7=0x1234 -> next cycle x7 not busy and reads 0x1234, busy_cnt=1.
- Set beats clear: x9 busy; same cycle write x9=0x55 and issue x9 -> x9 reads 0x55, rd_busy=1, busy_cnt unchanged.
- Bypass (RF_WR_BYPASS_EN only): write x3=0xDEAD_BEEF while reading x3 in the same cycle -> rd_data=0xDEAD_BEEF and rd_busy=0 in that cycle. Without the macro, the same cycle reads the old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file and its scoreboard.
// Optional build macro used by the consumers of this package: RF_WR_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NWR_DEF   = 2;
    localparam int unsigned NRD_DEF   = 4;
    localparam int unsigned NISS_DEF  = 2;

    // Widest vector popcount() accepts; callers zero-extend to this width.
    localparam int unsigned POP_MAX   = 1024;

    // Register address width for a power-of-two register count (>= 2).
    function automatic int unsigned addr_width(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    // Number of set bits in a vector.
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, writeback clears it,
// set beats clear. Register 0 is never busy.
// Build option: RF_WR_BYPASS_EN makes a same-cycle clear visible on rd_busy.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = NWR_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    parameter int unsigned NISS  = NISS_DEF,
    parameter int unsigned AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NISS-1:0]   iss_en,
    input  logic [NISS*AW-1:0] iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic [AW:0]       busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_v;
    logic [NREGS-1:0] clr_v;
    logic [NREGS-1:0] busy_nxt;

    // Decode issue/writeback strobes into per-register set/clear masks.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int unsigned j = 0; j < NISS; j++) begin
            if (iss_en[j]) set_v[iss_addr[j*AW +: AW]] = 1'b1;
        end
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wr_en[k]) clr_v[wr_addr[k*AW +: AW]] = 1'b1;
        end
        busy_nxt    = (busy & ~clr_v) | set_v;
        busy_nxt[0] = 1'b0;
    end

    // Busy vector and its population count, both from the same next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= CW'(popcount(POP_MAX'(busy_nxt)));
        end
    end

    // Per-read-port busy lookup.
    always_comb begin
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_busy[i] = busy[rd_addr[i*AW +: AW]];
`ifdef RF_WR_BYPASS_EN
            if (clr_v[rd_addr[i*AW +: AW]] && !set_v[rd_addr[i*AW +: AW]]) rd_busy[i] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/multiport_regfile_sb.sv
// Parametrised multi-port register file with busy-bit scoreboard.
// Owns the data array, write-port arbitration (lowest port wins) and read muxing.
// Build option: RF_WR_BYPASS_EN forwards same-cycle write data to the read ports.
module multiport_regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = NWR_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    parameter int unsigned NISS  = NISS_DEF,
    parameter int unsigned AW    = addr_width(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NISS-1:0]       iss_en,
    input  logic [NISS*AW-1:0]    iss_addr,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] we;
    logic [XLEN-1:0]  wd  [NREGS];

    // Per-register write select: first enabled port addressing it wins; x0 never written.
    always_comb begin
        we = '0;
        for (int unsigned r = 0; r < NREGS; r++) wd[r] = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            for (int unsigned k = 0; k < NWR; k++) begin
                if (wr_en[k] && (int'(wr_addr[k*AW +: AW]) == int'(r)) && !we[r]) begin
                    we[r] = 1'b1;
                    wd[r] = wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Data array update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (we[r]) mem[r] <= wd[r];
            end
        end
    end

    // Combinational read ports.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (rd_addr[i*AW +: AW] != '0) rd_data[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
`ifdef RF_WR_BYPASS_EN
            // Writes are discarded while in reset, so they are not forwarded either.
            if (rst_n && we[rd_addr[i*AW +: AW]]) rd_data[i*XLEN +: XLEN] = wd[rd_addr[i*AW +: AW]];
`endif
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .NRD   (NRD),
        .NISS  (NISS),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_multiport_regfile_sb.sv
// Self-checking bench for multiport_regfile_sb: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
// Honours RF_WR_BYPASS_EN for the expected same-cycle visibility.
module tb_multiport_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NWR = 2;
    localparam int NRD = 4;
    localparam int NISS = 2;
    localparam int AW = 5;

    logic                 clk;
    logic                 rst_n;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NISS-1:0]      iss_en;
    logic [NISS*AW-1:0]   iss_addr;
    logic [AW:0]          busy_cnt;

    int errors = 0;
    int checks = 0;

    multiport_regfile_sb #(
        .XLEN (XLEN), .NREGS (NREGS), .NWR (NWR), .NRD (NRD), .NISS (NISS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];

    function automatic int wa(input int k);  return int'(wr_addr[k*AW +: AW]);  endfunction
    function automatic int ia(input int j);  return int'(iss_addr[j*AW +: AW]); endfunction
    function automatic int ra(input int i);  return int'(rd_addr[i*AW +: AW]);  endfunction
    function automatic logic [XLEN-1:0] dout(input int i); return rd_data[i*XLEN +: XLEN]; endfunction

    // Architectural state after each edge: lowest port's data survives, set beats clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  <= '0;
                m_busy[r] <= 1'b0;
            end
        end else begin
            for (int k = NWR - 1; k >= 0; k--) begin
                if (wr_en[k] && wa(k) != 0) m_mem[wa(k)] <= wr_data[k*XLEN +: XLEN];
            end
            for (int k = 0; k < NWR; k++) if (wr_en[k]) m_busy[wa(k)] <= 1'b0;
            for (int j = 0; j < NISS; j++) if (iss_en[j] && ia(j) != 0) m_busy[ia(j)] <= 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
`ifdef RF_WR_BYPASS_EN
        if (rst_n) begin
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && wa(k) == a) return wr_data[k*XLEN +: XLEN];
        end
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef RF_WR_BYPASS_EN
        if (rst_n) begin
            bit wrote, issued;
            wrote = 0; issued = 0;
            for (int k = 0; k < NWR; k++) if (wr_en[k] && wa(k) == a) wrote = 1;
            for (int j = 0; j < NISS; j++) if (iss_en[j] && ia(j) == a) issued = 1;
            if (wrote && !issued) return 1'b0;
        end
`endif
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge, with inputs and state settled.
    always @(negedge clk) begin
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("model_rd_data[%0d] x%0d", i, ra(i)), 64'(dout(i)), 64'(exp_data(ra(i))));
            chk($sformatf("model_rd_busy[%0d] x%0d", i, ra(i)), 64'(rd_busy[i]), 64'(exp_busy(ra(i))));
        end
        chk("model_busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wr_en  = '0;
        iss_en = '0;
    endtask

    task automatic set_wr(input int k, input int a, input logic [XLEN-1:0] d);
        wr_en[k] = 1'b1;
        wr_addr[k*AW +: AW] = AW'(a);
        wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_iss(input int j, input int a);
        iss_en[j] = 1'b1;
        iss_addr[j*AW +: AW] = AW'(a);
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = '0; iss_addr = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Reset state.
        step();
        set_rd(0, 5); set_rd(1, 7); set_rd(2, 9); set_rd(3, 0);
        #1;
        chk("reset_rd_data_x5", 64'(dout(0)), 64'h0);
        chk("reset_rd_busy", 64'(rd_busy), 64'h0);
        chk("reset_busy_cnt", 64'(busy_cnt), 64'h0);

        // Write conflict on x5: port 0 wins.
        step();
        set_wr(0, 5, 32'hAAAA_0001); set_wr(1, 5, 32'hBBBB_0002);
        step(); idle(); #1;
        chk("conflict_x5", 64'(dout(0)), 64'hAAAA_0001);

        // Register 0: write and issue are both ignored.
        step();
        set_wr(0, 0, 32'hFFFF_FFFF); set_iss(0, 0);
        step(); idle(); #1;
        chk("x0_rd_data", 64'(dout(3)), 64'h0);
        chk("x0_rd_busy", 64'(rd_busy[3]), 64'h0);
        chk("x0_busy_cnt", 64'(busy_cnt), 64'd0);

        // Scoreboard lifecycle.
        step();
        set_iss(0, 7); set_iss(1, 9);
        step(); idle(); #1;
        chk("life_x7_busy", 64'(rd_busy[1]), 64'h1);
        chk("life_x9_busy", 64'(rd_busy[2]), 64'h1);
        chk("life_cnt2", 64'(busy_cnt), 64'd2);
        step();
        set_wr(1, 7, 32'h0000_1234);
        step(); idle(); #1;
        chk("life_x7_free", 64'(rd_busy[1]), 64'h0);
        chk("life_x7_data", 64'(dout(1)), 64'h1234);
        chk("life_cnt1", 64'(busy_cnt), 64'd1);

        // Set beats clear on x9.
        step();
        set_wr(0, 9, 32'h55); set_iss(1, 9);
        step(); idle(); #1;
        chk("sbc_x9_data", 64'(dout(2)), 64'h55);
        chk("sbc_x9_busy", 64'(rd_busy[2]), 64'h1);
        chk("sbc_cnt", 64'(busy_cnt), 64'd1);

        // Same-cycle write/read of x3 (x3 first made busy holding 0x1111).
        step();
        set_wr(0, 3, 32'h1111); set_iss(0, 3);
        step(); idle();
        set_rd(0, 3);
        set_wr(1, 3, 32'hDEAD_BEEF);
        #1;
`ifdef RF_WR_BYPASS_EN
        chk("same_cycle_x3_data", 64'(dout(0)), 64'hDEAD_BEEF);
        chk("same_cycle_x3_busy", 64'(rd_busy[0]), 64'h0);
`else
        chk("same_cycle_x3_data", 64'(dout(0)), 64'h1111);
        chk("same_cycle_x3_busy", 64'(rd_busy[0]), 64'h1);
`endif
        chk("same_cycle_cnt", 64'(busy_cnt), 64'd2);
        step(); idle(); #1;
        chk("next_cycle_x3_data", 64'(dout(0)), 64'hDEAD_BEEF);
        chk("next_cycle_x3_busy", 64'(rd_busy[0]), 64'h0);
        chk("next_cycle_cnt", 64'(busy_cnt), 64'd1);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 1500; c++) begin
            step();
            idle();
            for (int k = 0; k < NWR; k++)
                if ($urandom_range(0, 2) != 0) set_wr(k, rnd_addr(), $urandom());
            for (int j = 0; j < NISS; j++)
                if ($urandom_range(0, 2) == 0) set_iss(j, rnd_addr());
            for (int i = 0; i < NRD; i++) set_rd(i, rnd_addr());
        end

        // Asynchronous reset mid-cycle with both write ports and issues active.
        step();
        idle();
        for (int j = 0; j < NISS; j++) set_iss(j, 12 + j);
        set_wr(0, 10, 32'hCAFE_0010); set_wr(1, 11, 32'hCAFE_0011);
        set_rd(0, 5); set_rd(1, 9); set_rd(2, 10); set_rd(3, 11);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NRD; i++) chk($sformatf("async_rst_rd_data[%0d]", i), 64'(dout(i)), 64'h0);
        chk("async_rst_rd_busy", 64'(rd_busy), 64'h0);
        chk("async_rst_busy_cnt", 64'(busy_cnt), 64'h0);
        step();
        chk("rst_held_x10", 64'(dout(2)), 64'h0);
        chk("rst_held_cnt", 64'(busy_cnt), 64'h0);
        idle();
        #2 rst_n = 1'b1;
        step(); #1;
        chk("post_rst_x11", 64'(dout(3)), 64'h0);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
